// File: rtl/writeback_unit_pkg.sv
// Shared constants and encodings for the write-back stage: widths, result-source
// codes, load funct3 codes and controller states.
package writeback_unit_pkg;

    localparam int DATA_LEN     = 32;
    localparam int REG_ADDR_LEN = 5;

    typedef enum logic [1:0] {
        WB_SRC_ALU  = 2'b00,
        WB_SRC_MEM  = 2'b01,
        WB_SRC_PC4  = 2'b10,
        WB_SRC_NONE = 2'b11
    } wb_src_e;

    localparam logic [2:0] LOAD_LB  = 3'b000;
    localparam logic [2:0] LOAD_LH  = 3'b001;
    localparam logic [2:0] LOAD_LW  = 3'b010;
    localparam logic [2:0] LOAD_LBU = 3'b100;
    localparam logic [2:0] LOAD_LHU = 3'b101;

    typedef enum logic [1:0] {
        WB_IDLE     = 2'b00,
        WB_WAIT_MEM = 2'b01,
        WB_WRITE    = 2'b10
    } wb_state_e;

endpackage

// File: rtl/writeback_unit_load_formatter.sv
// Combinational load formatter: extracts byte/half/word from an aligned memory
// word, applies sign/zero extension and flags misaligned or illegal loads.
module writeback_unit_load_formatter
    import writeback_unit_pkg::*;
#(
    parameter int DATA_W = DATA_LEN
) (
    input  logic [1:0]        addr,
    input  logic [2:0]        funct3,
    input  logic [DATA_W-1:0] word,
    output logic [DATA_W-1:0] data,
    output logic              misaligned,
    output logic              illegal
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v     = word[{addr, 3'b000} +: 8];
        half_v     = word[{addr[1], 4'b0000} +: 16];
        data       = word;
        misaligned = 1'b0;
        illegal    = 1'b0;
        case (funct3)
            LOAD_LB:  data = {{(DATA_W-8){byte_v[7]}}, byte_v};
            LOAD_LBU: data = {{(DATA_W-8){1'b0}}, byte_v};
            LOAD_LH: begin
                data       = {{(DATA_W-16){half_v[15]}}, half_v};
                misaligned = addr[0];
            end
            LOAD_LHU: begin
                data       = {{(DATA_W-16){1'b0}}, half_v};
                misaligned = addr[0];
            end
            LOAD_LW:  misaligned = (addr != 2'b00);
            default:  illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/writeback_unit.sv
// Write-back controller: accepts one result, waits for load data if needed and
// drives the register-file write port. WB_FORWARD_EN adds a same-cycle bypass port.
module writeback_unit
    import writeback_unit_pkg::*;
#(
    parameter int DATA_W = DATA_LEN,
    parameter int ADDR_W = REG_ADDR_LEN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_rd,
    input  logic [1:0]        in_src,
    input  logic [DATA_W-1:0] in_alu_res,
    input  logic [DATA_W-1:0] in_pc,
    input  logic [2:0]        in_funct3,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              wb_done,
    output logic              wb_err
`ifdef WB_FORWARD_EN
    ,
    output logic              fwd_valid,
    output logic [ADDR_W-1:0] fwd_rd,
    output logic [DATA_W-1:0] fwd_data
`endif
);

    wb_state_e         state_q, state_d;
    logic [ADDR_W-1:0] rd_q, rd_d;
    logic [1:0]        addr_q, addr_d;
    logic [2:0]        funct3_q, funct3_d;
    logic              rf_we_q, rf_we_d;
    logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
    logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
    logic              wb_done_q, wb_done_d;
    logic              wb_err_q, wb_err_d;

    logic [1:0]        fmt_addr;
    logic [2:0]        fmt_funct3;
    logic [DATA_W-1:0] fmt_data;
    logic              fmt_misaligned;
    logic              fmt_illegal;

    // One formatter serves both the accept-time alignment check (live inputs)
    // and the load-data formatting in WAIT_MEM (latched address/funct3).
    assign fmt_addr   = (state_q == WB_IDLE) ? in_alu_res[1:0] : addr_q;
    assign fmt_funct3 = (state_q == WB_IDLE) ? in_funct3 : funct3_q;

    writeback_unit_load_formatter #(.DATA_W(DATA_W)) u_load_formatter (
        .addr       (fmt_addr),
        .funct3     (fmt_funct3),
        .word       (mem_rdata),
        .data       (fmt_data),
        .misaligned (fmt_misaligned),
        .illegal    (fmt_illegal)
    );

    assign in_ready = (state_q == WB_IDLE);

    always_comb begin
        state_d    = state_q;
        rd_d       = rd_q;
        addr_d     = addr_q;
        funct3_d   = funct3_q;
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        wb_done_d  = 1'b0;
        wb_err_d   = 1'b0;
        case (state_q)
            WB_IDLE: begin
                if (in_valid) begin
                    rd_d     = in_rd;
                    addr_d   = in_alu_res[1:0];
                    funct3_d = in_funct3;
                    if (in_src == WB_SRC_MEM) begin
                        if (fmt_misaligned || fmt_illegal) begin
                            wb_err_d = 1'b1;
                        end else begin
                            state_d = WB_WAIT_MEM;
                        end
                    end else begin
                        // Outputs are registered, so the WRITE-cycle values are set here.
                        state_d   = WB_WRITE;
                        wb_done_d = 1'b1;
                        if (in_rd != '0 && in_src != WB_SRC_NONE) begin
                            rf_we_d    = 1'b1;
                            rf_waddr_d = in_rd;
                            rf_wdata_d = (in_src == WB_SRC_PC4) ? in_pc + DATA_W'(4) : in_alu_res;
                        end
                    end
                end
            end
            WB_WAIT_MEM: begin
                if (mem_rvalid) begin
                    state_d   = WB_WRITE;
                    wb_done_d = 1'b1;
                    if (rd_q != '0) begin
                        rf_we_d    = 1'b1;
                        rf_waddr_d = rd_q;
                        rf_wdata_d = fmt_data;
                    end
                end
            end
            WB_WRITE: state_d = WB_IDLE;
            default:  state_d = WB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= WB_IDLE;
            rd_q       <= '0;
            addr_q     <= '0;
            funct3_q   <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            wb_done_q  <= 1'b0;
            wb_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_q       <= rd_d;
            addr_q     <= addr_d;
            funct3_q   <= funct3_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            wb_done_q  <= wb_done_d;
            wb_err_q   <= wb_err_d;
        end
    end

    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;
    assign wb_done  = wb_done_q;
    assign wb_err   = wb_err_q;

`ifdef WB_FORWARD_EN
    assign fwd_valid = rf_we_q;
    assign fwd_rd    = rf_waddr_q;
    assign fwd_data  = rf_wdata_q;
`endif

endmodule

// File: doc/writeback_unit.md
Name: writeback_unit

Overview:
Write-back stage controller for the multi-period CPU. It accepts one completed instruction result per transaction from the EX/MEM stages and waits for load data where needed. It formats the result (load extraction, sign/zero extension, PC+4) and drives the register file's single write port (we/waddr/wdata). It is the producer end of the register-file write interface.

Parameters:
DATA_W, `DATA_LEN (32), datapath width
ADDR_W, `REG_ADDR_LEN (5), register index width

Ports:
clk  in  1  system clock
rst  in  1  reset; synchronous, active-low (deasserted = 1)
in_valid  in  1  result transaction offered
in_ready  out  1  unit can accept a transaction
in_rd  in  ADDR_W  destination register index
in_src  in  2  source select: 00 ALU, 01 MEM load, 10 PC+4 (jal/jalr), 11 NONE (no write)
in_alu_res  in  DATA_W  ALU result; also the load address for MEM
in_pc  in  DATA_W  instruction PC
in_funct3  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
mem_rvalid  in  1  load data valid (single-cycle pulse)
mem_rdata  in  DATA_W  aligned 32-bit word read from memory
rf_we  out  1  register file write enable
rf_waddr  out  ADDR_W  register file write address
rf_wdata  out  DATA_W  register file write data
wb_done  out  1  one-cycle pulse when a transaction retires
wb_err  out  1  one-cycle pulse, misaligned or illegal load, no write

Behaviour:
- Reset: when rst==0 at a clk edge, state=IDLE, rf_we=0, rf_waddr=0, rf_wdata=0, wb_done=0, wb_err=0, and internal latches are cleared. A reset mid-transaction (including in WAIT_MEM) abandons it with no write. A late mem_rvalid after reset is ignored.
- States: IDLE, WAIT_MEM, WRITE.
- in_ready = (state==IDLE). Accept = in_valid & in_ready. On accept, latch rd, src, alu_res, pc, funct3.
- IDLE transitions on accept:
  - src ALU, PC4 or NONE -> WRITE.
  - src MEM -> check alignment first. LH/LHU with addr[0]=1, LW with addr[1:0]!=0, or funct3 in {011,110,111} -> wb_err pulse next cycle, wb_done=0, return to IDLE, no write.
  - Aligned MEM -> WAIT_MEM.
- WAIT_MEM: hold until mem_rvalid=1 and capture mem_rdata that cycle -> WRITE. There is no timeout. mem_rvalid in any other state is ignored.
- WRITE (one cycle): rf_we=1 only if rd!=0 and src!=NONE, with rf_waddr=rd and rf_wdata=formatted value. wb_done=1. Next state IDLE.
- rf_we, rf_waddr, rf_wdata and wb_done are registered outputs, valid in the WRITE cycle. Outside WRITE, rf_we=0 and wb_done=0; rf_waddr/rf_wdata hold their last value.
- Formatting:
  - ALU: alu_res.
  - PC4: pc+4, mod 2^32 (0xFFFFFFFC -> 0x00000000).
  - MEM: byte = rdata[8*addr[1:0] +: 8], half = rdata[16*addr[1] +: 16]. LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- Latency: ALU/PC4 accept at cycle T -> rf_we at T+1 -> in_ready again at T+2. MEM: WRITE is the cycle after mem_rvalid.
- Throughput: at most 1 transaction per 2 cycles.

Optional Feature:
WB_FORWARD_EN.
- Defined: adds outputs fwd_valid (1), fwd_rd (ADDR_W) and fwd_data (DATA_W).
  - fwd_valid=1 in WRITE when rf_we=1, with fwd_rd/fwd_data equal to rf_waddr/rf_wdata, for same-cycle bypass to the operand latch.
  - In WAIT_MEM, fwd_valid=0.
- Undefined: ports absent; behaviour otherwise identical.

Decomposition:
- defines.v (shared, `include`): DATA_LEN, REG_ADDR_LEN, WB_SRC_ALU/MEM/PC4/NONE codes, LOAD_LB/LH/LW/LBU/LHU funct3 codes, WB state encodings.
- One combinational sub-module, load_formatter (addr[1:0], funct3, word -> data, misaligned, illegal), shared later by the pipelined core.

Test Plan:
- ALU write: in_src=00, rd=5, alu_res=0x12345678 accepted at T -> rf_we=1, waddr=5, wdata=0x12345678, wb_done=1 at T+1; in_ready=1 at T+2.
- Loads: LB at addr=0x...3 with rdata=0x80FF0011 -> wdata=0xFFFFFF80; LBU same -> 0x00000080; LHU at addr=0x...2 -> 0x000080FF; LH -> 0xFFFF80FF.
- Wait and ignore: MEM accepted, mem_rvalid delayed 5 cycles -> in_ready=0 throughout, single write exactly one cycle after mem_rvalid. A spurious mem_rvalid in IDLE -> no write.
- Error path: LW at addr=0x...2 -> wb_err pulse at T+1, rf_we=0, wb_done=0, in_ready=1 at T+2. funct3=011 -> wb_err.
- x0 / NONE / PC4: rd=0 with ALU -> wb_done=1, rf_we=0. src=NONE -> wb_done=1, rf_we=0. PC4 with pc=0xFFFFFFFC, rd=1 -> wdata=0x00000000.
- Reset: rst=0 asserted while in WAIT_MEM, then mem_rvalid -> no rf_we, outputs at reset values, in_ready=1 after rst returns to 1. With WB_FORWARD_EN, fwd_* mirror rf_* during WRITE.
